tile_writeback: RTL and testbench

Drains one finished colour tile from the rasterizer's double-buffered tile outputs into the frame buffer. It sits directly downstream of the rasterizer. On a start pulse it snapshots the selected tile (0 or 1) together with the tile's screen offset. It then streams the tile's pixels, row-major, as single-word writes over a ready/valid write port, clipping any pixel that falls off-screen. This lets the rasterizer fill the other buffer while the write-back runs.

---
 rtl/tile_writeback.sv | 182 ++++++++++++++++++
 tb/tb_tile_writeback.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_writeback.sv
// tile_writeback: copies one finished colour tile from the rasterizer's
// double-buffered tile outputs into the frame buffer. On start it snapshots the
// selected tile and its screen offset, then streams the pixels row-major as
// single-word ready/valid writes. Pixels that fall off-screen are skipped.
module tile_writeback #(
  parameter int unsigned tileDim      = 8,
  parameter int unsigned screenWidth  = 640,
  parameter int unsigned screenHeight = 480,
  parameter int unsigned addrWidth    = 19
) (
  input  logic                 BOARD_CLK,
  input  logic                 RESET_N,
  input  logic                 writebackStart,
  input  logic                 writebackTileID,
  input  logic [9:0]           tileOffsetX,
  input  logic [9:0]           tileOffsetY,
  input  logic [15:0]          cBufferTile0 [tileDim][tileDim],
  input  logic [15:0]          cBufferTile1 [tileDim][tileDim],
  output logic                 fbWrite,
  output logic [addrWidth-1:0] fbAddr,
  output logic [15:0]          fbData,
  input  logic                 fbReady,
  output logic                 writebackBusy,
  output logic                 writebackDone
);

  localparam int unsigned CntW   = (tileDim > 1) ? $clog2(tileDim) : 1;
  localparam int unsigned CoordW = 11;
  localparam int unsigned OffW   = 10;
  localparam int unsigned PixW   = 16;
  localparam logic [CntW-1:0] LastIdx = CntW'(tileDim - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        col_q, col_d;
  logic [CntW-1:0]        row_q, row_d;
  // every pixel of the tile has been placed in the output slot
  logic                   issued_all_q, issued_all_d;
  logic [OffW-1:0]        off_x_q, off_x_d;
  logic [OffW-1:0]        off_y_q, off_y_d;
  logic                   fb_write_q, fb_write_d;
  logic [addrWidth-1:0]   fb_addr_q, fb_addr_d;
  logic [PixW-1:0]        fb_data_q, fb_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [PixW-1:0]        snap_q [tileDim][tileDim];
  logic                   snap_load;

  logic [CoordW-1:0]      sx, sy;
  logic                   clip;
  logic [addrWidth-1:0]   addr_calc;
  logic                   slot_free;

  // Output slot holds one pixel; the counters name the next pixel to load.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    issued_all_d = issued_all_q;
    off_x_d      = off_x_q;
    off_y_d      = off_y_q;
    fb_write_d   = fb_write_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    snap_load    = 1'b0;

    sx        = CoordW'(off_x_q) + CoordW'(col_q);
    sy        = CoordW'(off_y_q) + CoordW'(row_q);
    clip      = (32'(sx) >= screenWidth) || (32'(sy) >= screenHeight);
    addr_calc = addrWidth'(sy) * addrWidth'(screenWidth) + addrWidth'(sx);
    // the slot can take a new pixel when empty or when its write is accepted
    slot_free = !fb_write_q || fbReady;

    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        fb_write_d = 1'b0;
        if (writebackStart) begin
          snap_load    = 1'b1;
          off_x_d      = tileOffsetX;
          off_y_d      = tileOffsetY;
          col_d        = '0;
          row_d        = '0;
          issued_all_d = 1'b0;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        busy_d = 1'b1;
        if (slot_free) begin
          if (!issued_all_q) begin
            fb_write_d = !clip;
            if (!clip) begin
              fb_addr_d = addr_calc;
              fb_data_d = snap_q[col_q][row_q];
            end
            if (col_q == LastIdx) begin
              col_d = '0;
              if (row_q == LastIdx) begin
                issued_all_d = 1'b1;
              end else begin
                row_d = row_q + CntW'(1);
              end
            end else begin
              col_d = col_q + CntW'(1);
            end
          end else begin
            fb_write_d = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        busy_d     = 1'b0;
        fb_write_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        fb_write_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      issued_all_q <= 1'b0;
      off_x_q      <= '0;
      off_y_q      <= '0;
      fb_write_q   <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      issued_all_q <= issued_all_d;
      off_x_q      <= off_x_d;
      off_y_q      <= off_y_d;
      fb_write_q   <= fb_write_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Tile snapshot, captured only on an accepted start so the rasterizer may
  // refill its buffers while the write-back runs.
  always_ff @(posedge BOARD_CLK) begin
    if (snap_load) begin
      if (writebackTileID) begin
        snap_q <= cBufferTile1;
      end else begin
        snap_q <= cBufferTile0;
      end
    end
  end

  assign fbWrite       = fb_write_q;
  assign fbAddr        = fb_addr_q;
  assign fbData        = fb_data_q;
  assign writebackBusy = busy_q;
  assign writebackDone = done_q;

endmodule

// File: tb/tb_tile_writeback.sv
// Testbench for tile_writeback: directed and randomized tiles checked against a
// behavioural list of expected frame-buffer writes.
module tb_tile_writeback;

  localparam int TD = 8;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int AW = 19;

  logic          BOARD_CLK;
  logic          RESET_N;
  logic          writebackStart;
  logic          writebackTileID;
  logic [9:0]    tileOffsetX;
  logic [9:0]    tileOffsetY;
  logic [15:0]   tile0 [TD][TD];
  logic [15:0]   tile1 [TD][TD];
  logic          fbWrite;
  logic [AW-1:0] fbAddr;
  logic [15:0]   fbData;
  logic          fbReady;
  logic          writebackBusy;
  logic          writebackDone;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;

  int got_addr[$];
  int got_data[$];
  int exp_addr[$];
  int exp_data[$];
  int done_cnt;
  int done_cyc;
  int stall_viol;
  bit stall_pend;
  logic [AW-1:0] p_addr;
  logic [15:0]   p_data;

  tile_writeback #(
    .tileDim(TD), .screenWidth(SW), .screenHeight(SH), .addrWidth(AW)
  ) dut (
    .BOARD_CLK      (BOARD_CLK),
    .RESET_N        (RESET_N),
    .writebackStart (writebackStart),
    .writebackTileID(writebackTileID),
    .tileOffsetX    (tileOffsetX),
    .tileOffsetY    (tileOffsetY),
    .cBufferTile0   (tile0),
    .cBufferTile1   (tile1),
    .fbWrite        (fbWrite),
    .fbAddr         (fbAddr),
    .fbData         (fbData),
    .fbReady        (fbReady),
    .writebackBusy  (writebackBusy),
    .writebackDone  (writebackDone)
  );

  initial BOARD_CLK = 1'b0;
  always #5 BOARD_CLK = ~BOARD_CLK;

  always @(posedge BOARD_CLK) cyc <= cyc + 1;

  // fbReady pattern: 0 = always ready, 1 = toggling, 2 = random
  always @(posedge BOARD_CLK) begin
    #1;
    if (rdy_mode == 0) fbReady = 1'b1;
    else if (rdy_mode == 1) fbReady = !fbReady;
    else fbReady = 1'($urandom_range(0, 1));
  end

  // Write collector: logs accepted writes, done pulses and stall stability.
  always @(negedge BOARD_CLK) begin
    if (!RESET_N) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && (!fbWrite || fbAddr !== p_addr || fbData !== p_data))
        stall_viol++;
      if (fbWrite && fbReady) begin
        got_addr.push_back(int'(fbAddr));
        got_data.push_back(int'(fbData));
      end
      stall_pend = fbWrite && !fbReady;
      p_addr = fbAddr;
      p_data = fbData;
      if (writebackDone) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    stall_viol = 0;
  endtask

  // Expected write list: every on-screen pixel, row-major, address y*W+x.
  function automatic void build_model(input bit id, input int ox, input int oy);
    exp_addr.delete();
    exp_data.delete();
    for (int y = 0; y < TD; y++) begin
      for (int x = 0; x < TD; x++) begin
        int px = ox + x;
        int py = oy + y;
        if (px < SW && py < SH) begin
          exp_addr.push_back((py * SW + px) % (1 << AW));
          exp_data.push_back(int'(id ? tile1[x][y] : tile0[x][y]));
        end
      end
    end
  endfunction

  task automatic fill_rand();
    for (int x = 0; x < TD; x++)
      for (int y = 0; y < TD; y++) begin
        tile0[x][y] = 16'($urandom);
        tile1[x][y] = 16'($urandom);
      end
  endtask

  // Runs one tile from a start pulse; called at posedge+2.
  task automatic run_tile(input string tag, input bit id, input int ox, input int oy,
                          input int mode, input int exp_lat, input bit disturb,
                          input int tail);
    int  start_cyc;
    bit  timeout;
    build_model(id, ox, oy);
    clear_mon();
    rdy_mode = mode;
    if (mode == 1) fbReady = 1'b0;
    writebackTileID = id;
    tileOffsetX     = 10'(ox);
    tileOffsetY     = 10'(oy);
    writebackStart  = 1'b1;
    @(posedge BOARD_CLK);
    #2;
    start_cyc      = cyc;
    writebackStart = 1'b0;
    timeout        = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge BOARD_CLK);
      #1;
      if (i == 1) check({tag, ".busy"}, writebackBusy, 1);
      if (disturb && i == 4) begin
        writebackStart  = 1'b1;
        writebackTileID = ~id;
        tileOffsetX     = 10'($urandom_range(0, 100));
        tileOffsetY     = 10'($urandom_range(0, 100));
        fill_rand();
      end
      if (disturb && i == 5) writebackStart = 1'b0;
      if (done_cnt > 0) begin
        timeout = 1'b0;
        break;
      end
    end
    check({tag, ".done_timeout"}, timeout, 0);
    if (exp_lat >= 0) check({tag, ".done_latency"}, done_cyc - start_cyc, exp_lat);
    repeat (tail) @(posedge BOARD_CLK);
    #2;
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".done_low"}, writebackDone, 0);
    check({tag, ".busy_idle"}, writebackBusy, 0);
    check({tag, ".write_count"}, got_addr.size(), exp_addr.size());
    check({tag, ".stall_stable"}, stall_viol, 0);
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k < got_addr.size()) begin
        check($sformatf("%s.addr[%0d]", tag, k), got_addr[k], exp_addr[k]);
        check($sformatf("%s.data[%0d]", tag, k), got_data[k], exp_data[k]);
      end
    end
  endtask

  initial begin
    int n_at;
    bit timeout;
    writebackStart  = 1'b0;
    writebackTileID = 1'b0;
    tileOffsetX     = '0;
    tileOffsetY     = '0;
    fbReady         = 1'b1;
    stall_pend      = 1'b0;
    clear_mon();
    for (int x = 0; x < TD; x++)
      for (int y = 0; y < TD; y++) begin
        tile0[x][y] = '0;
        tile1[x][y] = '0;
      end

    // power-on reset
    RESET_N = 1'b1;
    #2 RESET_N = 1'b0;
    #1;
    check("reset.fbWrite", fbWrite, 0);
    check("reset.fbAddr", fbAddr, 0);
    check("reset.fbData", fbData, 0);
    check("reset.busy", writebackBusy, 0);
    check("reset.done", writebackDone, 0);
    repeat (3) @(negedge BOARD_CLK);
    RESET_N = 1'b1;
    @(posedge BOARD_CLK);
    #2;

    // basic tile: pixel[x][y] = {y,x}
    for (int x = 0; x < TD; x++)
      for (int y = 0; y < TD; y++)
        tile1[x][y] = 16'((y << 8) | x);
    run_tile("basic", 1'b1, 16, 8, 0, 65, 1'b0, 1);
    check("basic.first_addr", got_addr[0], 5136);
    check("basic.first_data", got_data[0], 16'h0000);
    check("basic.ninth_addr", got_addr[8], 5776);
    check("basic.ninth_data", got_data[8], 16'h0100);
    check("basic.last_addr", got_addr[63], 9623);

    run_tile("backpressure", 1'b1, 16, 8, 1, 129, 1'b0, 1);

    run_tile("clip", 1'b1, 636, 476, 0, 65, 1'b0, 1);
    check("clip.first_addr", got_addr[0], 476 * 640 + 636);
    check("clip.last_addr", got_addr[15], 479 * 640 + 639);

    // offset near the 10-bit limit must clip rather than wrap
    run_tile("fullclip", 1'b0, 1020, 5, 0, 65, 1'b0, 1);

    fill_rand();
    run_tile("snapshot", 1'b0, 100, 50, 0, 65, 1'b1, 100);

    for (int x = 0; x < TD; x++)
      for (int y = 0; y < TD; y++) begin
        tile0[x][y] = 16'hF800;
        tile1[x][y] = 16'h07E0;
      end
    run_tile("select0", 1'b0, 0, 0, 0, 65, 1'b0, 1);
    check("select0.data", got_data[0], 16'hF800);
    run_tile("select1", 1'b1, 8, 0, 0, 65, 1'b0, 1);
    check("select1.data", got_data[0], 16'h07E0);

    for (int r = 0; r < 4; r++) begin
      int ox;
      int oy;
      fill_rand();
      ox = (r % 2) ? $urandom_range(620, 645) : $urandom_range(0, 600);
      oy = (r % 2) ? $urandom_range(460, 485) : $urandom_range(0, 400);
      run_tile($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), ox, oy, 2, -1, 1'b0, 1);
    end

    // reset in the middle of a tile
    rdy_mode = 0;
    clear_mon();
    fill_rand();
    writebackTileID = 1'b1;
    tileOffsetX     = 10'd16;
    tileOffsetY     = 10'd8;
    writebackStart  = 1'b1;
    @(posedge BOARD_CLK);
    #2;
    writebackStart = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge BOARD_CLK);
      #1;
      if (got_addr.size() >= 10) begin
        timeout = 1'b0;
        break;
      end
    end
    check("midreset.wait", timeout, 0);
    @(posedge BOARD_CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("midreset.fbWrite", fbWrite, 0);
    check("midreset.fbAddr", fbAddr, 0);
    check("midreset.fbData", fbData, 0);
    check("midreset.busy", writebackBusy, 0);
    check("midreset.done", writebackDone, 0);
    n_at = got_addr.size();
    @(negedge BOARD_CLK);
    RESET_N = 1'b1;
    repeat (80) @(posedge BOARD_CLK);
    #2;
    check("midreset.no_writes", got_addr.size(), n_at);
    check("midreset.no_done", done_cnt, 0);
    check("midreset.idle", writebackBusy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
